rx_frame_ctrl: RTL and testbench

Frame sequencer for the receive path. It watches the per-byte strobe from the rx datapath and counts bytes in the current frame. A frame is closed after an idle gap of RxTimeOutSet_i baud ticks, or when the byte count saturates. On close it pushes a 28-bit frame record (byte count, millisecond stamp, 0.1 ms stamp) into an internal frame-info queue, which the host reads through n_rd_frame_fifo_i.

---
 rtl/rx_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: counts bytes per frame, closes on idle timeout or count saturation,
// and queues {byte count, ms stamp, 0.1 ms stamp} records. Optional: RX_FRAME_SECOND_STAMP_EN.
module rx_frame_ctrl #(
    parameter int FRAME_DEPTH = 8,
    parameter int PTR_W       = 3,
    parameter int CNT_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_Enable_i,
    input  logic                 p_FrameFunctionEnable_i,
    input  logic [15:0]          RxTimeOutSet_i,
    input  logic                 BaudSig_i,
    input  logic                 p_DataReceived_i,
    input  logic [11:0]          millisecond_stamp_i,
    input  logic [3:0]           acqurate_stamp_i,
`ifdef RX_FRAME_SECOND_STAMP_EN
    input  logic [31:0]          second_stamp_i,
    output logic [31:0]          frame_second_o,
`endif
    input  logic                 n_rd_frame_fifo_i,
    output logic [CNT_W+15:0]    frame_info_o,
    output logic                 p_FrameInfoValid_o,
    output logic [PTR_W:0]       FrameNum_o,
    output logic                 p_FrameOverflow_o,
    output logic                 p_FrameClosed_o
);

    localparam int REC_W = CNT_W + 16;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        RECEIVING = 3'b010,
        CLOSE     = 3'b100
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [15:0]        idle_cnt;
    logic [15:0]        idle_nxt;
    logic [11:0]        ms_q;
    logic [3:0]         acq_q;
    logic               frame_en;
    logic               latch_stamp;

    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [REC_W-1:0]   rec_mem [FRAME_DEPTH];
    logic               q_empty;
    logic               q_full;
    logic               push_req;
    logic               do_push;
    logic               do_pop;

    assign frame_en    = p_Enable_i & p_FrameFunctionEnable_i;
    assign latch_stamp = frame_en & p_DataReceived_i;
    assign idle_nxt    = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else if (!frame_en) begin
            state    <= IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p_DataReceived_i) begin
                        state    <= RECEIVING;
                        byte_cnt <= CNT_ONE;
                        idle_cnt <= '0;
                    end
                end
                RECEIVING: begin
                    // A byte in the same cycle as a baud tick restarts the idle gap.
                    if (p_DataReceived_i) begin
                        byte_cnt <= byte_cnt + CNT_ONE;
                        idle_cnt <= '0;
                        if (byte_cnt == CNT_LAST)
                            state <= CLOSE;
                    end else if (BaudSig_i) begin
                        idle_cnt <= idle_nxt;
                        if (RxTimeOutSet_i != 16'd0 && idle_nxt == RxTimeOutSet_i)
                            state <= CLOSE;
                    end
                end
                CLOSE: begin
                    idle_cnt <= '0;
                    if (p_DataReceived_i) begin
                        state    <= RECEIVING;
                        byte_cnt <= CNT_ONE;
                    end else begin
                        state    <= IDLE;
                        byte_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_q  <= '0;
            acq_q <= '0;
        end else if (latch_stamp) begin
            ms_q  <= millisecond_stamp_i;
            acq_q <= acqurate_stamp_i;
        end
    end

    assign q_empty  = (wr_ptr == rd_ptr);
    assign q_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_req = (state == CLOSE);
    assign do_pop   = !n_rd_frame_fifo_i && !q_empty;
    // A pop frees the slot the push writes into when full, so both happen on one edge.
    assign do_push  = push_req && (!q_full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            p_FrameOverflow_o <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !do_push)
                p_FrameOverflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            rec_mem[wr_ptr[PTR_W-1:0]] <= {byte_cnt, ms_q, acq_q};
    end

    assign frame_info_o       = q_empty ? '0 : rec_mem[rd_ptr[PTR_W-1:0]];
    assign p_FrameInfoValid_o = !q_empty;
    assign FrameNum_o         = wr_ptr - rd_ptr;
    assign p_FrameClosed_o    = (state == CLOSE);

`ifdef RX_FRAME_SECOND_STAMP_EN
    logic [31:0] sec_q;
    logic [31:0] sec_mem [FRAME_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sec_q <= '0;
        else if (latch_stamp)
            sec_q <= second_stamp_i;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            sec_mem[wr_ptr[PTR_W-1:0]] <= sec_q;
    end

    assign frame_second_o = q_empty ? '0 : sec_mem[rd_ptr[PTR_W-1:0]];
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: per-cycle vector table for timeout framing and the
// byte/baud race, plus hand sequences for saturation, overflow, abort and async reset.
module tb_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_Enable_i = 1'b1;
    logic        p_FrameFunctionEnable_i = 1'b1;
    logic [15:0] RxTimeOutSet_i = 16'd10;
    logic        BaudSig_i = 1'b0;
    logic        p_DataReceived_i = 1'b0;
    logic [11:0] millisecond_stamp_i = '0;
    logic [3:0]  acqurate_stamp_i = '0;
    logic        n_rd_frame_fifo_i = 1'b1;
    logic [27:0] frame_info_o;
    logic        p_FrameInfoValid_o;
    logic [3:0]  FrameNum_o;
    logic        p_FrameOverflow_o;
    logic        p_FrameClosed_o;
`ifdef RX_FRAME_SECOND_STAMP_EN
    logic [31:0] second_stamp_i = '0;
    logic [31:0] frame_second_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_frame_ctrl #(.FRAME_DEPTH(8), .PTR_W(3), .CNT_W(12)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .p_Enable_i              (p_Enable_i),
        .p_FrameFunctionEnable_i (p_FrameFunctionEnable_i),
        .RxTimeOutSet_i          (RxTimeOutSet_i),
        .BaudSig_i               (BaudSig_i),
        .p_DataReceived_i        (p_DataReceived_i),
        .millisecond_stamp_i     (millisecond_stamp_i),
        .acqurate_stamp_i        (acqurate_stamp_i),
`ifdef RX_FRAME_SECOND_STAMP_EN
        .second_stamp_i          (second_stamp_i),
        .frame_second_o          (frame_second_o),
`endif
        .n_rd_frame_fifo_i       (n_rd_frame_fifo_i),
        .frame_info_o            (frame_info_o),
        .p_FrameInfoValid_o      (p_FrameInfoValid_o),
        .FrameNum_o              (FrameNum_o),
        .p_FrameOverflow_o       (p_FrameOverflow_o),
        .p_FrameClosed_o         (p_FrameClosed_o)
    );

    typedef struct {
        logic        byte_v;
        logic        baud;
        logic        rd_n;
        logic [11:0] ms;
        logic [3:0]  acq;
        logic        closed;
        logic        valid;
        logic [3:0]  num;
        logic [27:0] info;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic b, input logic bd, input logic rdn, input int ms, input int acq,
                        input logic cl, input logic vl, input int num, input logic [27:0] info);
        vec_t v;
        v.byte_v = b;   v.baud = bd;   v.rd_n = rdn;
        v.ms = 12'(ms); v.acq = 4'(acq);
        v.closed = cl;  v.valid = vl;  v.num = 4'(num); v.info = info;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock with optional byte / baud pulses; returns 1 time unit after the edge.
    task automatic cycle(input logic b, input logic bd);
        p_DataReceived_i = b;
        BaudSig_i        = bd;
        @(posedge clk); #1;
        p_DataReceived_i = 1'b0;
        BaudSig_i        = 1'b0;
    endtask

    task automatic pop();
        n_rd_frame_fifo_i = 1'b0;
        @(posedge clk); #1;
        n_rd_frame_fifo_i = 1'b1;
    endtask

    task automatic reset_dut();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // nb back-to-back bytes, then a 2-tick timeout; returns one cycle after CLOSE.
    task automatic make_frame(input int nb, input int tag);
        millisecond_stamp_i = 12'(tag);
        acqurate_stamp_i    = 4'(tag);
        RxTimeOutSet_i      = 16'd2;
        for (int k = 0; k < nb; k++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    function automatic logic [27:0] rec(input int cnt, input int ms, input int acq);
        return {12'(cnt), 12'(ms), 4'(acq)};
    endfunction

    initial begin
        // Single frame, timeout 10; last byte carries ms=123 / acq=7.
        addv(1,0,1,  5,1, 0,0,0,0);
        addv(0,1,1,  5,1, 0,0,0,0);
        addv(0,1,1,  5,1, 0,0,0,0);
        addv(1,0,1, 50,2, 0,0,0,0);
        addv(0,1,1, 50,2, 0,0,0,0);
        addv(0,1,1, 50,2, 0,0,0,0);
        addv(1,0,1,123,7, 0,0,0,0);
        for (int i = 0; i < 9; i++) addv(0,1,1,999,9, 0,0,0,0);
        addv(0,1,1,999,9, 1,0,0,0);
        addv(0,0,1,999,9, 0,1,1,28'h00307B7);
        addv(0,0,0,999,9, 0,0,0,0);
        // Byte coincides with the 10th tick: frame continues with count 2.
        addv(1,0,1,1,1, 0,0,0,0);
        for (int i = 0; i < 9; i++) addv(0,1,1,1,1, 0,0,0,0);
        addv(1,1,1,2,2, 0,0,0,0);
        for (int i = 0; i < 9; i++) addv(0,1,1,2,2, 0,0,0,0);
        addv(0,1,1,2,2, 1,0,0,0);
        addv(0,0,1,2,2, 0,1,1,28'h0020022);
        addv(0,0,0,2,2, 0,0,0,0);

        #12;
        chk("rst_info",  32'(frame_info_o), 0);
        chk("rst_valid", 32'(p_FrameInfoValid_o), 0);
        chk("rst_num",   32'(FrameNum_o), 0);
        chk("rst_ovf",   32'(p_FrameOverflow_o), 0);
        chk("rst_closed",32'(p_FrameClosed_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            millisecond_stamp_i = tbl[i].ms;
            acqurate_stamp_i    = tbl[i].acq;
            n_rd_frame_fifo_i   = tbl[i].rd_n;
            cycle(tbl[i].byte_v, tbl[i].baud);
            n_rd_frame_fifo_i   = 1'b1;
            chk($sformatf("vec%0d_closed", i), 32'(p_FrameClosed_o),    32'(tbl[i].closed));
            chk($sformatf("vec%0d_valid",  i), 32'(p_FrameInfoValid_o), 32'(tbl[i].valid));
            chk($sformatf("vec%0d_num",    i), 32'(FrameNum_o),         32'(tbl[i].num));
            chk($sformatf("vec%0d_info",   i), 32'(frame_info_o),       32'(tbl[i].info));
        end

        // Saturation: 4095 bytes, timeout disabled; byte 4096 lands in CLOSE.
        RxTimeOutSet_i = 16'd0;
        millisecond_stamp_i = 12'd7;
        acqurate_stamp_i    = 4'd3;
        for (int k = 1; k <= 4095; k++) begin
            cycle(1'b1, 1'b0);
            if (k == 4094) chk("sat_closed_4094", 32'(p_FrameClosed_o), 0);
            if (k == 4095) chk("sat_closed_4095", 32'(p_FrameClosed_o), 1);
        end
        millisecond_stamp_i = 12'd8;
        acqurate_stamp_i    = 4'd4;
        cycle(1'b1, 1'b0);
        chk("sat_closed_after", 32'(p_FrameClosed_o), 0);
        chk("sat_num",  32'(FrameNum_o), 1);
        chk("sat_info", 32'(frame_info_o), 32'(28'hFFF0073));
        RxTimeOutSet_i = 16'd3;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("sat_new_closed", 32'(p_FrameClosed_o), 1);
        cycle(1'b0, 1'b0);
        chk("sat_new_num", 32'(FrameNum_o), 2);
        pop();
        chk("sat_new_info", 32'(frame_info_o), 32'(rec(1, 8, 4)));
        chk("sat_new_num1", 32'(FrameNum_o), 1);
        pop();
        chk("sat_empty", 32'(p_FrameInfoValid_o), 0);

        // Overflow: 9 frames into an 8-deep queue, ninth dropped.
        for (int i = 0; i < 9; i++) make_frame(i + 1, i);
        chk("ovf_num",   32'(FrameNum_o), 8);
        chk("ovf_flag",  32'(p_FrameOverflow_o), 1);
        chk("ovf_valid", 32'(p_FrameInfoValid_o), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_head%0d", i), 32'(frame_info_o), 32'(rec(i + 1, i, i)));
            pop();
        end
        chk("ovf_lost9", 32'(p_FrameInfoValid_o), 0);
        chk("ovf_sticky", 32'(p_FrameOverflow_o), 1);

        reset_dut();
        chk("ovf_cleared", 32'(p_FrameOverflow_o), 0);

        // Full queue with pop coincident with CLOSE: push accepted, no overflow.
        for (int i = 0; i < 8; i++) make_frame(1, i);
        chk("full_num", 32'(FrameNum_o), 8);
        millisecond_stamp_i = 12'd8;
        acqurate_stamp_i    = 4'd8;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("full_closing", 32'(p_FrameClosed_o), 1);
        pop();
        chk("full_pp_num", 32'(FrameNum_o), 8);
        chk("full_pp_ovf", 32'(p_FrameOverflow_o), 0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("full_head%0d", i), 32'(frame_info_o), 32'(rec(1, i, i)));
            pop();
        end
        chk("full_drained", 32'(FrameNum_o), 0);

        // Abort: frame function disabled after 2 bytes.
        RxTimeOutSet_i = 16'd5;
        millisecond_stamp_i = 12'd3;
        acqurate_stamp_i    = 4'd3;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        p_FrameFunctionEnable_i = 1'b0;
        cycle(1'b0, 1'b0);
        p_FrameFunctionEnable_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            chk($sformatf("abort_closed%0d", i), 32'(p_FrameClosed_o), 0);
        end
        chk("abort_num", 32'(FrameNum_o), 0);
        millisecond_stamp_i = 12'd9;
        acqurate_stamp_i    = 4'd9;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("abort_pre", 32'(p_FrameClosed_o), 0);
        cycle(1'b0, 1'b1);
        chk("abort_closed", 32'(p_FrameClosed_o), 1);
        cycle(1'b0, 1'b0);
        chk("abort_info", 32'(frame_info_o), 32'(rec(1, 9, 9)));
        chk("abort_num1", 32'(FrameNum_o), 1);

        // Async reset mid-frame with 2 records queued.
        make_frame(2, 4);
        chk("ar_num_pre", 32'(FrameNum_o), 2);
        cycle(1'b1, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk("ar_info",   32'(frame_info_o), 0);
        chk("ar_valid",  32'(p_FrameInfoValid_o), 0);
        chk("ar_num",    32'(FrameNum_o), 0);
        chk("ar_ovf",    32'(p_FrameOverflow_o), 0);
        chk("ar_closed", 32'(p_FrameClosed_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            chk($sformatf("ar_idle%0d", i), 32'(p_FrameClosed_o), 0);
        end
        chk("ar_empty", 32'(p_FrameInfoValid_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
